// File: rtl/alu_seq.sv
// Sequential accumulator ALU: single-cycle arithmetic/logic ops plus iterative
// shift-add multiply and restoring divide, one bit per cycle.
//
// state  | meaning
// S_IDLE | waiting for start; single-cycle ops and DIV-by-zero complete here
// S_MUL  | shift-add multiply iterating, busy high
// S_DIV  | restoring unsigned divide iterating, busy high
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int CONST_W = 12
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALU_control,
  input  logic [CONST_W-1:0] const_in,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   AC_out,
  output logic [WIDTH-1:0]   REM_out,
  output logic               Z_out,
  output logic               N_out,
  output logic               C_out,
  output logic               DZ_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_LDB = 4'b0101;
  localparam logic [3:0] OP_LDC = 4'b0110;
  localparam logic [3:0] OP_INC = 4'b0111;
  localparam logic [3:0] OP_DEC = 4'b1000;
  localparam logic [3:0] OP_CLR = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod, mcand, prod_nxt;
  logic [WIDTH-1:0]   opb, quo, rem, quo_nxt, rem_nxt;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   ac_sc;
  logic               c_sc;
  logic               accept, last_iter, div_zero;

  assign accept    = start && (state == S_IDLE);
  assign last_iter = (cnt == CNT_W'(1));
  assign div_zero  = (B == '0);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && ALU_control == OP_MUL)                   state_nxt = S_MUL;
        else if (accept && ALU_control == OP_DIV && !div_zero) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (last_iter) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // One iteration step of each long operation.
  always_comb begin
    prod_nxt = opb[0] ? prod + mcand : prod;
    div_sh   = {rem, quo[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opb};
    if (div_diff[WIDTH+1]) begin
      rem_nxt = div_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = div_diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    ac_sc = AC_out;
    c_sc  = C_out;
    case (ALU_control)
      OP_ADD: {c_sc, ac_sc} = {1'b0, AC_out} + {1'b0, B};
      OP_SUB: {c_sc, ac_sc} = {1'b0, AC_out} - {1'b0, B};
      OP_LDB: ac_sc = B;
      OP_LDC: ac_sc = WIDTH'(const_in);
      OP_INC: {c_sc, ac_sc} = {1'b0, AC_out} + (WIDTH+1)'(1);
      OP_DEC: {c_sc, ac_sc} = {1'b0, AC_out} - (WIDTH+1)'(1);
      OP_CLR: ac_sc = '0;
      OP_AND: ac_sc = AC_out & B;
      OP_OR:  ac_sc = AC_out | B;
      OP_SHL: begin
        c_sc  = AC_out[WIDTH-1];
        ac_sc = {AC_out[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        c_sc  = AC_out[0];
        ac_sc = {1'b0, AC_out[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      AC_out  <= '0;
      REM_out <= '0;
      C_out   <= 1'b0;
      DZ_out  <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
      opb     <= '0;
      quo     <= '0;
      rem     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            DZ_out <= 1'b0;
            if (ALU_control == OP_MUL) begin
              prod  <= '0;
              mcand <= {{WIDTH{1'b0}}, AC_out};
              opb   <= B;
              cnt   <= CNT_W'(WIDTH);
            end else if (ALU_control == OP_DIV) begin
              if (div_zero) begin
                DZ_out <= 1'b1;
                done   <= 1'b1;
              end else begin
                quo <= AC_out;
                rem <= '0;
                opb <= B;
                cnt <= CNT_W'(WIDTH);
              end
            end else begin
              AC_out <= ac_sc;
              C_out  <= c_sc;
              done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod  <= prod_nxt;
          mcand <= mcand << 1;
          opb   <= opb >> 1;
          cnt   <= cnt - CNT_W'(1);
          if (last_iter) begin
            AC_out <= prod_nxt[WIDTH-1:0];
            C_out  <= |prod_nxt[2*WIDTH-1:WIDTH];
            done   <= 1'b1;
          end
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CNT_W'(1);
          if (last_iter) begin
            AC_out  <= quo_nxt;
            REM_out <= rem_nxt;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Z_out = (AC_out == '0);
  assign N_out = AC_out[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed checks of alu_seq against an arithmetic reference
// model of the accumulator, remainder and flags.
module tb_alu_seq;

  localparam int W = 16;
  localparam int K = 12;

  logic         clock = 1'b0;
  logic         rst_n;
  logic [W-1:0] B;
  logic [3:0]   ALU_control;
  logic [K-1:0] const_in;
  logic         start;
  logic         busy, done, Z_out, N_out, C_out, DZ_out;
  logic [W-1:0] AC_out, REM_out;

  int n_chk  = 0;
  int n_fail = 0;

  int unsigned m_ac, m_rem;
  bit          m_c, m_dz;

  alu_seq #(.WIDTH(W), .CONST_W(K)) dut (
    .clock(clock), .rst_n(rst_n), .B(B), .ALU_control(ALU_control),
    .const_in(const_in), .start(start), .busy(busy), .done(done),
    .AC_out(AC_out), .REM_out(REM_out), .Z_out(Z_out), .N_out(N_out),
    .C_out(C_out), .DZ_out(DZ_out)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ac = 0; m_rem = 0; m_c = 0; m_dz = 0;
  endtask

  task automatic model_op(input logic [3:0] op, input int unsigned b, input int unsigned k);
    m_dz = 0;
    case (op)
      4'd1:  begin m_c = (m_ac + b) > 65535; m_ac = (m_ac + b) % 65536; end
      4'd2:  begin m_c = m_ac < b; m_ac = (m_ac + 65536 - b) % 65536; end
      4'd3:  begin m_c = (m_ac * b) >= 65536; m_ac = (m_ac * b) % 65536; end
      4'd4:  if (b == 0) m_dz = 1;
             else begin m_rem = m_ac % b; m_ac = m_ac / b; end
      4'd5:  m_ac = b;
      4'd6:  m_ac = k;
      4'd7:  begin m_c = (m_ac == 65535); m_ac = (m_ac + 1) % 65536; end
      4'd8:  begin m_c = (m_ac == 0); m_ac = (m_ac + 65535) % 65536; end
      4'd9:  m_ac = 0;
      4'd10: m_ac = m_ac & b;
      4'd11: m_ac = m_ac | b;
      4'd12: begin m_c = (m_ac >= 32768); m_ac = (m_ac * 2) % 65536; end
      4'd13: begin m_c = m_ac % 2; m_ac = m_ac / 2; end
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ac"},  AC_out,  m_ac);
    check({tag, ".rem"}, REM_out, m_rem);
    check({tag, ".c"},   C_out,   m_c);
    check({tag, ".dz"},  DZ_out,  m_dz);
    check({tag, ".z"},   Z_out,   m_ac == 0);
    check({tag, ".n"},   N_out,   m_ac >= 32768);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".ac"},   AC_out,  0);
    check({tag, ".rem"},  REM_out, 0);
    check({tag, ".c"},    C_out,   0);
    check({tag, ".dz"},   DZ_out,  0);
    check({tag, ".busy"}, busy,    0);
    check({tag, ".done"}, done,    0);
    check({tag, ".z"},    Z_out,   1);
    check({tag, ".n"},    N_out,   0);
  endtask

  task automatic idle(input string tag);
    start = 1'b0;
    @(posedge clock); #1;
    check({tag, ".done_low"}, done, 0);
    check({tag, ".busy_low"}, busy, 0);
  endtask

  // Issue one op; with meddle set, B changes and an ADD is requested mid-iteration.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] b,
                        input logic [K-1:0] k, input bit meddle);
    int  cycles;
    int  dones;
    bit  is_long;
    ALU_control = op; B = b; const_in = k; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    is_long = (op == 4'd3) || (op == 4'd4 && b != 0);
    model_op(op, b, k);
    if (is_long) begin
      check({tag, ".busy_acc"}, busy, 1);
      cycles = 0;
      dones  = 0;
      while (busy && cycles < 40) begin
        if (meddle && cycles == 3) begin
          B = 16'h0005; ALU_control = 4'd1; start = 1'b1;
        end else start = 1'b0;
        @(posedge clock); #1;
        cycles++;
        if (busy) dones += done;
      end
      start = 1'b0;
      check({tag, ".busy_len"}, cycles, W);
      check({tag, ".done_early"}, dones, 0);
      check({tag, ".done"}, done, 1);
    end else begin
      check({tag, ".busy"}, busy, 0);
      check({tag, ".done"}, done, 1);
    end
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; B = '0; ALU_control = '0; const_in = '0;
    model_reset();
    #12;
    check_reset("por");
    @(posedge clock); #1;
    rst_n = 1'b1;

    run_op("ldc_abc", 4'd6, 16'h0, 12'hABC, 0);
    idle("ldc_abc");
    #2 rst_n = 1'b0;
    #1 check_reset("rst_async");
    @(posedge clock); #1;
    check_reset("rst_held");
    rst_n = 1'b1;
    model_reset();
    run_op("ldc_abc2", 4'd6, 16'h0, 12'hABC, 0);

    run_op("clr", 4'd9, 16'h0, 12'h0, 0);
    run_op("dec0", 4'd8, 16'h0, 12'h0, 0);
    run_op("add2", 4'd1, 16'h0002, 12'h0, 0);
    run_op("sub2", 4'd2, 16'h0002, 12'h0, 0);
    run_op("inc_ffff", 4'd7, 16'h0, 12'h0, 0);

    run_op("ldc_123", 4'd6, 16'h0, 12'h123, 0);
    run_op("mul", 4'd3, 16'h0100, 12'h0, 1);
    idle("mul");
    check("mul.ac_2300", AC_out, 16'h2300);

    run_op("ldc_1000", 4'd6, 16'h0, 12'd1000, 0);
    run_op("div7", 4'd4, 16'd7, 12'h0, 0);
    check("div7.q", AC_out, 142);
    check("div7.r", REM_out, 6);
    run_op("div0", 4'd4, 16'd0, 12'h0, 0);
    idle("div0");
    run_op("nop", 4'd0, 16'h1234, 12'h0, 0);

    run_op("ldc_800", 4'd6, 16'h0, 12'h800, 0);
    for (int i = 0; i < 4; i++) run_op("shl_8000", 4'd12, 16'h0, 12'h0, 0);
    ALU_control = 4'd4; B = 16'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clock); #1; end
    check("abort.busy_mid", busy, 1);
    rst_n = 1'b0;
    #1 check_reset("abort");
    model_reset();
    repeat (2) begin @(posedge clock); #1; end
    check("abort.done_held", done, 0);
    rst_n = 1'b1;
    run_op("ldc_5", 4'd6, 16'h0, 12'd5, 0);

    run_op("ldc_f0f", 4'd6, 16'h0, 12'hF0F, 0);
    for (int i = 0; i < 4; i++) run_op("shl_f0f0", 4'd12, 16'h0, 12'h0, 0);
    run_op("and", 4'd10, 16'h0FF0, 12'h0, 0);
    run_op("or", 4'd11, 16'h0F00, 12'h0, 0);
    run_op("shl", 4'd12, 16'h0, 12'h0, 0);
    for (int i = 0; i < 5; i++) run_op("shr", 4'd13, 16'h0, 12'h0, 0);
    check("shr.ac_00ff", AC_out, 16'h00FF);

    for (int i = 0; i < 300; i++) begin
      logic [3:0]   op;
      logic [W-1:0] b;
      logic [K-1:0] k;
      op = 4'($urandom_range(0, 15));
      b  = 16'($urandom);
      k  = 12'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      else if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 15));
      run_op("rnd", op, b, k, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential accumulator ALU: the next-generation arithmetic core of the processor datapath. It holds the accumulator and executes one operation per `start` request against the bus operand `B` or a zero-extended instruction constant. Multiply and divide are iterative (one bit per cycle) behind a `busy`/`done` handshake. Beyond the basic ALU it adds a remainder output, carry/borrow, negative and divide-by-zero flags, logic/shift ops, and a reset.

## Interface
- `WIDTH`, 16, accumulator/bus/result width (≥4).
- `CONST_W`, 12, constant field width; must be ≤ `WIDTH`.
- `clock`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `B`  in  WIDTH  bus operand.
- `ALU_control`  in  4  opcode, sampled on accept.
- `const_in`  in  CONST_W  constant field from the instruction.
- `start`  in  1  operation request.
- `busy`  out  1  high while a MUL/DIV iterates.
- `done`  out  1  one-cycle pulse when a result is committed.
- `AC_out`  out  WIDTH  accumulator.
- `REM_out`  out  WIDTH  remainder of last successful DIV.
- `Z_out`  out  1  `AC_out == 0` (combinational from AC).
- `N_out`  out  1  `AC_out[WIDTH-1]`.
- `C_out`  out  1  carry/borrow/overflow flag (registered).
- `DZ_out`  out  1  divide-by-zero flag (registered).

## Operation
- **Opcodes:**
  - 0000 NOP.
  - 0001 AC+B.
  - 0010 AC−B.
  - 0011 AC×B.
  - 0100 AC÷B.
  - 0101 AC=B.
  - 0110 AC={0,const_in}.
  - 0111 AC+1.
  - 1000 AC−1.
  - 1001 AC=0.
  - 1010 AC&B.
  - 1011 AC|B.
  - 1100 AC<<1 (C = shifted-out MSB).
  - 1101 AC>>1 logical (C = shifted-out LSB).
  - 1110/1111 NOP.
- **Accept:** a request is accepted at a rising edge where `start=1` and `busy=0`. `start` while `busy=1` is ignored (not queued).
- **Single-cycle ops** (all except 0011/0100):
  - AC and C are written at the accepting edge.
  - `done=1` for the following cycle.
  - `busy` stays 0.
- **C rules:**
  - ADD: carry-out.
  - SUB: borrow (`AC<B`, unsigned).
  - INC: 1 iff AC was all-ones.
  - DEC: 1 iff AC was 0.
  - Shifts: as listed above.
  - All other single-cycle ops: C held.
- **States:** IDLE, MUL, DIV.
- **IDLE → MUL/DIV on accept:**
  - Latches AC and B into internal operand registers; later changes on `B` are ignored.
  - Loads the iteration counter with WIDTH.
- **MUL:** shift-add, one bit per cycle, 2·WIDTH-bit product.
  - On the last iteration: AC = product[WIDTH-1:0]; C = |product[2·WIDTH-1:WIDTH].
- **DIV:** restoring, unsigned, one bit per cycle.
  - On the last iteration: AC = quotient, REM_out = remainder; C held.
- **DIV with B==0 at accept:**
  - No iteration; state stays IDLE.
  - AC and REM unchanged; DZ_out=1.
  - `done` pulses as for a single-cycle op.
- **DZ_out:** cleared at every other accepted operation.
- **Reset mid-operation:** aborts the iteration immediately; nothing is committed.

## Timing
- **Reset values** (async on `rst_n=0`, held while low):
  - AC_out=0, REM_out=0.
  - C_out=0, DZ_out=0.
  - busy=0, done=0, state IDLE.
  - Z_out=1, N_out=0.
- **First accept:** possible at the first rising edge after `rst_n` deasserts.
- **Single-cycle latency:** accept edge E0 → AC valid after E0; `done` high in cycle E0..E1. Back-to-back accepts are allowed every cycle.
- **MUL/DIV latency:** accept at E0.
  - `busy` is high from E0 to E_WIDTH.
  - AC/REM/C commit at E_WIDTH; `busy` falls at E_WIDTH.
  - `done` is high in cycle E_WIDTH..E_WIDTH+1.
  - A new accept is possible at E_WIDTH+1. Total = WIDTH+1 edges to next accept.
- **Flags:** `done` is never high in two consecutive cycles for one op. Z_out/N_out follow AC_out with no extra latency.

## Test plan
- **Reset + load:** assert `rst_n=0` mid-cycle → all outputs at reset values asynchronously. Release, then LOADC `const_in=0xABC` → AC=0x0ABC, done one cycle, busy never high, Z=0.
- **Carry/wrap:**
  - AC=0xFFFF, ADD B=0x0002 → AC=0x0001, C=1.
  - Then SUB B=0x0002 → AC=0xFFFF, C=1, N=1.
  - DEC from 0 → 0xFFFF, C=1; INC from 0xFFFF → 0, Z=1, C=1.
- **MUL:** AC=0x0123, MUL B=0x0100.
  - Change B to 0x0005 during busy and pulse `start` with ADD.
  - Required: busy 16 cycles, then AC=0x2300, C=1, a single done; the ADD is not executed.
- **DIV:**
  - AC=1000, DIV B=7 → after 16 busy cycles AC=142, REM_out=6, DZ=0.
  - Then DIV B=0 → AC=142 and REM_out=6 unchanged, DZ=1, done next cycle, busy never high.
  - Then NOP → DZ=0.
- **Reset mid-DIV:** AC=0x8000, DIV B=3, assert `rst_n=0` at iteration 8 → AC=0, busy=0, no done.
  - Release, then LOADC 5 → AC=5 normally.
- **Logic/shift:**
  - AC=0xF0F0: AND B=0x0FF0 → 0x00F0.
  - OR B=0x0F00 → 0x0FF0.
  - SHL → 0x1FE0, C=0.
  - SHR ×5 → 0x00FF, C=0 on the last shift.
